// File: rtl/hazard_controller.sv
// hazard_controller: pipeline hazard/stall controller.
// Drives stall/flush of the F/D/E/M/W pipe registers and the E-stage forwarding
// selects. A small FSM sequences multi-cycle divides in E and data-memory wait
// states in M. A saturating counter tracks cycles with stallF asserted.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   Rs1D, Rs2D                D-stage source registers
//   Rs1E, Rs2E, RdE           E-stage source/destination registers
//   RdM, RdW                  M/W destination registers
//   ResultSrcE0               E instruction is a load
//   DivE                      E instruction is a divide/remainder
//   PCSrcE                    taken branch/jump resolved in E
//   RegWriteM, RegWriteW      M/W write the register file
//   mem_req_M, mem_ready      M data-memory request / completion
//   stallF..stallM            hold pipe registers (combinational)
//   flushD..flushW            bubble pipe registers (combinational)
//   ForwardAE, ForwardBE      00 regfile, 01 W result, 10 M ALU result
//   div_start, div_valid      divider launch pulse / result valid in E
//   stall_cycles              saturating count of cycles with stallF=1
module hazard_controller #(
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           Rs1D,
  input  logic [4:0]           Rs2D,
  input  logic [4:0]           Rs1E,
  input  logic [4:0]           Rs2E,
  input  logic [4:0]           RdE,
  input  logic [4:0]           RdM,
  input  logic [4:0]           RdW,
  input  logic                 ResultSrcE0,
  input  logic                 DivE,
  input  logic                 PCSrcE,
  input  logic                 RegWriteM,
  input  logic                 RegWriteW,
  input  logic                 mem_req_M,
  input  logic                 mem_ready,
  output logic                 stallF,
  output logic                 stallD,
  output logic                 stallE,
  output logic                 stallM,
  output logic                 flushD,
  output logic                 flushE,
  output logic                 flushM,
  output logic                 flushW,
  output logic [1:0]           ForwardAE,
  output logic [1:0]           ForwardBE,
  output logic                 div_start,
  output logic                 div_valid,
  output logic [CNT_WIDTH-1:0] stall_cycles
);

  localparam int unsigned DIV_CNT_W = 8;
  localparam logic [DIV_CNT_W-1:0] DIV_LOAD = DIV_CNT_W'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DIV_BUSY = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t               state, state_next;
  logic [DIV_CNT_W-1:0] div_cnt, div_cnt_next;
  logic                 mem_stall;
  logic                 lw_stall;

  assign mem_stall = mem_req_M && !mem_ready;
  assign lw_stall  = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

  // Next-state and combinational outputs; reset forces flushes and silences the rest.
  always_comb begin
    state_next   = state;
    div_cnt_next = div_cnt;
    stallF       = 1'b0;
    stallD       = 1'b0;
    stallE       = 1'b0;
    stallM       = 1'b0;
    flushD       = 1'b0;
    flushE       = 1'b0;
    flushM       = 1'b0;
    flushW       = 1'b0;
    ForwardAE    = 2'b00;
    ForwardBE    = 2'b00;
    div_start    = 1'b0;
    div_valid    = 1'b0;

    if (rst) begin
      flushD = 1'b1;
      flushE = 1'b1;
      flushM = 1'b1;
      flushW = 1'b1;
    end else begin
      // M has priority over W; x0 is never forwarded.
      if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))      ForwardAE = 2'b10;
      else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) ForwardAE = 2'b01;
      if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))      ForwardBE = 2'b10;
      else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) ForwardBE = 2'b01;

      unique case (state)
        RUN: begin
          if (mem_stall) begin
            // Memory wait wins; a pending divide waits until M drains.
            stallF     = 1'b1;
            stallD     = 1'b1;
            stallE     = 1'b1;
            stallM     = 1'b1;
            flushW     = 1'b1;
            state_next = MEM_WAIT;
          end else if (DivE) begin
            div_start    = 1'b1;
            stallF       = 1'b1;
            stallD       = 1'b1;
            stallE       = 1'b1;
            flushM       = 1'b1;
            div_cnt_next = DIV_LOAD;
            state_next   = DIV_BUSY;
          end else if (PCSrcE) begin
            // Redirect squashes the wrong-path D instruction, so its load-use is moot.
            flushD = 1'b1;
            flushE = 1'b1;
          end else if (lw_stall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
          end
        end

        MEM_WAIT: begin
          if (!mem_ready) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushW = 1'b1;
          end else begin
            state_next = RUN;
          end
        end

        DIV_BUSY: begin
          // M only holds bubbles here, so memory requests are ignored.
          if (div_cnt != '0) begin
            stallF       = 1'b1;
            stallD       = 1'b1;
            stallE       = 1'b1;
            flushM       = 1'b1;
            div_cnt_next = div_cnt - DIV_CNT_W'(1);
          end else begin
            div_valid  = 1'b1;
            state_next = RUN;
          end
        end

        default: state_next = RUN;
      endcase
    end
  end

  // State, divide counter and saturating stall-cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      div_cnt      <= '0;
      stall_cycles <= '0;
    end else begin
      state   <= state_next;
      div_cnt <= div_cnt_next;
      if (stallF && (stall_cycles != {CNT_WIDTH{1'b1}})) begin
        stall_cycles <= stall_cycles + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed self-checking bench for hazard_controller.
// Main instance uses DIV_CYCLES=4; a second instance with CNT_WIDTH=4 shares
// the stimulus and is used to observe counter saturation.
module tb_hazard_controller;

  logic       clk;
  logic       rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       ResultSrcE0, DivE, PCSrcE, RegWriteM, RegWriteW, mem_req_M, mem_ready;

  logic        stallF, stallD, stallE, stallM;
  logic        flushD, flushE, flushM, flushW;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        div_start, div_valid;
  logic [31:0] stall_cycles;

  logic        s_stallF, s_stallD, s_stallE, s_stallM;
  logic        s_flushD, s_flushE, s_flushM, s_flushW;
  logic [1:0]  s_ForwardAE, s_ForwardBE;
  logic        s_div_start, s_div_valid;
  logic [3:0]  s_stall_cycles;

  int n_chk  = 0;
  int n_pass = 0;

  hazard_controller #(.DIV_CYCLES(4), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .ResultSrcE0(ResultSrcE0), .DivE(DivE), .PCSrcE(PCSrcE),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .mem_req_M(mem_req_M), .mem_ready(mem_ready),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .div_start(div_start), .div_valid(div_valid), .stall_cycles(stall_cycles)
  );

  hazard_controller #(.DIV_CYCLES(4), .CNT_WIDTH(4)) dut_s (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .ResultSrcE0(ResultSrcE0), .DivE(DivE), .PCSrcE(PCSrcE),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .mem_req_M(mem_req_M), .mem_ready(mem_ready),
    .stallF(s_stallF), .stallD(s_stallD), .stallE(s_stallE), .stallM(s_stallM),
    .flushD(s_flushD), .flushE(s_flushE), .flushM(s_flushM), .flushW(s_flushW),
    .ForwardAE(s_ForwardAE), .ForwardBE(s_ForwardBE),
    .div_start(s_div_start), .div_valid(s_div_valid), .stall_cycles(s_stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one clock; inputs are then driven 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] stv();
    return {stallF, stallD, stallE, stallM};
  endfunction

  function automatic logic [3:0] flv();
    return {flushD, flushE, flushM, flushW};
  endfunction

  task automatic clear_inputs();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    ResultSrcE0 = 1'b0; DivE = 1'b0; PCSrcE = 1'b0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; mem_req_M = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    // Forwarding condition present during reset must not leak out.
    RdM = 5'd5; Rs1E = 5'd5; RegWriteM = 1'b1;
    #2;
    chk("rst_flush", 32'(flv()), 32'hF);
    chk("rst_stall", 32'(stv()), 32'h0);
    chk("rst_fwdA",  32'(ForwardAE), 32'h0);
    chk("rst_div",   32'({div_start, div_valid}), 32'h0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_cnt", stall_cycles, 32'd0);

    // Forwarding: M over W, then W, then x0 suppression.
    RdM = 5'd5; RdW = 5'd5; Rs1E = 5'd5; Rs2E = 5'd5; RegWriteM = 1'b1; RegWriteW = 1'b1;
    #1;
    chk("fwd_A_M", 32'(ForwardAE), 32'h2);
    chk("fwd_B_M", 32'(ForwardBE), 32'h2);
    chk("fwd_nostall", 32'(stv()), 32'h0);
    RegWriteM = 1'b0;
    #1;
    chk("fwd_A_W", 32'(ForwardAE), 32'h1);
    chk("fwd_B_W", 32'(ForwardBE), 32'h1);
    RdM = 5'd0; RdW = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0; RegWriteM = 1'b1;
    #1;
    chk("fwd_A_x0", 32'(ForwardAE), 32'h0);
    RdM = 5'd7; RdW = 5'd9; Rs1E = 5'd9; Rs2E = 5'd7;
    #1;
    chk("fwd_A_mix", 32'(ForwardAE), 32'h1);
    chk("fwd_B_mix", 32'(ForwardBE), 32'h2);
    clear_inputs();
    tick();

    // Load-use: one stall cycle, counter +1.
    ResultSrcE0 = 1'b1; RdE = 5'd3; Rs2D = 5'd3;
    #1;
    chk("lw_stall", 32'(stv()), 32'hC);
    chk("lw_flush", 32'(flv()), 32'h4);
    tick();
    ResultSrcE0 = 1'b0; RdE = 5'd0; Rs2D = 5'd0;
    #1;
    chk("lw_release", 32'(stv()), 32'h0);
    chk("lw_cnt", stall_cycles, 32'd1);
    // Load to x0 is not a hazard.
    ResultSrcE0 = 1'b1; RdE = 5'd0; Rs1D = 5'd0;
    #1;
    chk("lw_x0", 32'(stv()), 32'h0);
    // Branch overrides load-use.
    RdE = 5'd3; Rs2D = 5'd3; PCSrcE = 1'b1;
    #1;
    chk("br_stall", 32'(stv()), 32'h0);
    chk("br_flush", 32'(flv()), 32'hC);
    clear_inputs();
    tick();

    // Divide with DIV_CYCLES=4, DivE held high.
    do_reset();
    DivE = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("div_start_c%0d", i), 32'(div_start), 32'(i == 0 || i == 5));
      chk($sformatf("div_stallE_c%0d", i), 32'(stallE), 32'(i < 4 || i == 5));
      chk($sformatf("div_valid_c%0d", i), 32'(div_valid), 32'(i == 4));
      if (i == 4) chk("div_cnt", stall_cycles, 32'd4);
      if (i < 5) tick();
    end
    // Cycle 5 restarted a divide; reach its second DIV_BUSY cycle and reset.
    tick();
    tick();
    #1;
    chk("dbusy_stall", 32'(stv()), 32'hE);
    rst = 1'b1;
    #1;
    chk("drst_flush", 32'(flv()), 32'hF);
    chk("drst_stall", 32'(stv()), 32'h0);
    chk("drst_valid", 32'(div_valid), 32'h0);
    tick();
    rst = 1'b0;
    DivE = 1'b0;
    #1;
    chk("drst_cnt", stall_cycles, 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("drst_run_c%0d", i), 32'({stv(), div_valid}), 32'h0);
      tick();
    end

    // Memory wait of 3 cycles with a pending divide.
    do_reset();
    mem_req_M = 1'b1; mem_ready = 1'b0; DivE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("mw_stall_c%0d", i), 32'(stv()), 32'hF);
      chk($sformatf("mw_flush_c%0d", i), 32'(flv()), 32'h1);
      chk($sformatf("mw_dstart_c%0d", i), 32'(div_start), 32'h0);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    chk("mw_rel_stall", 32'(stv()), 32'h0);
    chk("mw_rel_flush", 32'(flv()), 32'h0);
    chk("mw_rel_dstart", 32'(div_start), 32'h0);
    tick();
    mem_req_M = 1'b0;
    #1;
    chk("mw_div_start", 32'(div_start), 32'h1);
    chk("mw_div_stall", 32'(stv()), 32'hE);
    chk("mw_div_flush", 32'(flv()), 32'h2);
    chk("mw_cnt", stall_cycles, 32'd3);
    DivE = 1'b0;
    do_reset();

    // Zero wait states: no stall and no state change.
    mem_req_M = 1'b1; mem_ready = 1'b1;
    #1;
    chk("mw0_stall", 32'(stv()), 32'h0);
    tick();
    mem_req_M = 1'b0; mem_ready = 1'b0;
    #1;
    chk("mw0_after", 32'(stv()), 32'h0);
    chk("mw0_cnt", stall_cycles, 32'd0);

    // Counter saturation on the 4-bit instance.
    do_reset();
    mem_req_M = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    #1;
    chk("sat_cnt4", 32'(s_stall_cycles), 32'd15);
    chk("sat_cnt32", stall_cycles, 32'd20);
    mem_ready = 1'b1;
    tick();
    clear_inputs();
    tick();
    chk("sat_hold", 32'(s_stall_cycles), 32'd15);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
